// File: rtl/piso_serializer.sv
// Parallel-in serial-out shifter with a one-word holding register so the next word can be
// queued while the current one is still shifting out, giving gap-free back-to-back frames.
module piso_serializer #(
  parameter int unsigned DATA_W     = 8,
  parameter bit          MSB_FIRST  = 1'b0,
  parameter bit          IDLE_LEVEL = 1'b0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              bit_en,
  output logic              serial_out,
  output logic              bit_valid,
  output logic              frame_start,
  output logic              frame_last
);

  localparam int unsigned     CntW    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DATA_W - 1);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] hold_data_q, hold_data_d;
  logic              hold_full_q, hold_full_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              accept, word_done, load;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      hold_data_q <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      hold_data_q <= hold_data_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    hold_data_d = hold_data_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;

    accept    = in_valid && !hold_full_q;
    word_done = (state_q == StIdle) || (cnt_q == CntLast);
    // Accept and load are mutually exclusive: accept needs an empty holder, load a full one.
    load      = bit_en && hold_full_q && word_done;

    if (accept) begin
      hold_data_d = in_data;
      hold_full_d = 1'b1;
    end

    if (bit_en) begin
      unique case (state_q)
        StIdle:  if (hold_full_q) state_d = StShift;
        StShift: if ((cnt_q == CntLast) && !hold_full_q) state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end

    if (load) begin
      shift_d     = hold_data_q;
      cnt_d       = '0;
      hold_full_d = 1'b0;
    end else if (bit_en && (state_q == StShift) && (cnt_q != CntLast)) begin
      cnt_d = cnt_q + CntW'(1);
      if (MSB_FIRST) shift_d = {shift_q[DATA_W-2:0], 1'b0};
      else           shift_d = {1'b0, shift_q[DATA_W-1:1]};
    end
  end

  always_comb begin
    in_ready    = !hold_full_q;
    bit_valid   = (state_q == StShift);
    serial_out  = IDLE_LEVEL;
    if (bit_valid) serial_out = MSB_FIRST ? shift_q[DATA_W-1] : shift_q[0];
    frame_start = bit_valid && (cnt_q == '0);
    frame_last  = bit_valid && (cnt_q == CntLast);
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed + random bench for piso_serializer: an LSB-first and an MSB-first instance share
// stimulus and are compared every cycle against a word/bit-index reference model.
module tb_piso_serializer;

  logic       clk;
  logic       reset_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       bit_en;

  logic l_ready, l_ser, l_bv, l_fs, l_fl;
  logic m_ready, m_ser, m_bv, m_fs, m_fl;

  piso_serializer #(.DATA_W(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_lsb (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (l_ready),
    .bit_en     (bit_en),
    .serial_out (l_ser),
    .bit_valid  (l_bv),
    .frame_start(l_fs),
    .frame_last (l_fl)
  );

  piso_serializer #(.DATA_W(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) dut_msb (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (m_ready),
    .bit_en     (bit_en),
    .serial_out (m_ser),
    .bit_valid  (m_bv),
    .frame_start(m_fs),
    .frame_last (m_fl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  // Reference model: words waiting (at most one), word on the wire and its bit index (-1 idle).
  logic [7:0] pend[$];
  logic [7:0] cur;
  int         idx;
  int         acc_cnt;

  // Serial bits observed while bit_valid, for reassembly checks.
  logic rx_l[$];
  logic rx_m[$];
  int   bv_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string ph);
    logic busy;
    logic e_ser_l, e_ser_m;
    busy    = (idx >= 0);
    e_ser_l = 1'b0;
    e_ser_m = 1'b1;
    if (busy) begin
      e_ser_l = cur[idx];
      e_ser_m = cur[7-idx];
    end
    check({ph, ":ready_l"}, 32'(l_ready), 32'(pend.size() == 0));
    check({ph, ":ready_m"}, 32'(m_ready), 32'(pend.size() == 0));
    check({ph, ":ser_l"},   32'(l_ser),   32'(e_ser_l));
    check({ph, ":ser_m"},   32'(m_ser),   32'(e_ser_m));
    check({ph, ":bv_l"},    32'(l_bv),    32'(busy));
    check({ph, ":bv_m"},    32'(m_bv),    32'(busy));
    check({ph, ":fs_l"},    32'(l_fs),    32'(idx == 0));
    check({ph, ":fs_m"},    32'(m_fs),    32'(idx == 0));
    check({ph, ":fl_l"},    32'(l_fl),    32'(idx == 7));
    check({ph, ":fl_m"},    32'(m_fl),    32'(idx == 7));
  endtask

  task automatic model_step(input logic v, input logic [7:0] d, input logic e);
    logic accept;
    accept = v && (pend.size() == 0);
    if (e) begin
      if (idx >= 0 && idx < 7) idx++;
      else if (pend.size() != 0) begin
        cur = pend.pop_front();
        idx = 0;
      end else idx = -1;
    end
    if (accept) begin
      pend.push_back(d);
      acc_cnt++;
    end
  endtask

  task automatic cycle(input string ph, input logic v, input logic [7:0] d, input logic e);
    in_valid = v;
    in_data  = d;
    bit_en   = e;
    check_outputs(ph);
    if (l_bv) begin
      rx_l.push_back(l_ser);
      bv_cnt++;
    end
    if (m_bv) rx_m.push_back(m_ser);
    @(posedge clk);
    model_step(v, d, e);
    @(negedge clk);
  endtask

  task automatic clear_rx();
    rx_l.delete();
    rx_m.delete();
    bv_cnt = 0;
  endtask

  function automatic logic [7:0] word_l(input int base, input int stride);
    logic [7:0] w;
    for (int k = 0; k < 8; k++) w[k] = rx_l[base + k * stride];
    return w;
  endfunction

  function automatic logic [7:0] word_m(input int base, input int stride);
    logic [7:0] w;
    for (int k = 0; k < 8; k++) w[7-k] = rx_m[base + k * stride];
    return w;
  endfunction

  initial begin
    int base;
    n_vec    = 0;
    n_err    = 0;
    idx      = -1;
    cur      = '0;
    acc_cnt  = 0;
    bv_cnt   = 0;
    in_valid = 1'b0;
    in_data  = '0;
    bit_en   = 1'b0;
    reset_n  = 1'b1;
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check_outputs("reset");
    reset_n = 1'b1;
    @(negedge clk);

    // Single word, bit_en tied high.
    clear_rx();
    cycle("a5", 1'b1, 8'hA5, 1'b1);
    repeat (11) cycle("a5", 1'b0, 8'h00, 1'b1);
    check("a5:nbits", 32'(bv_cnt), 32'd8);
    check("a5:word_l", 32'(word_l(0, 1)), 32'h A5);
    check("a5:word_m", 32'(word_m(0, 1)), 32'h A5);

    // Back-to-back words with in_valid held; data switches right after the first handshake.
    clear_rx();
    base = acc_cnt;
    for (int i = 0; i < 30; i++)
      cycle("b2b", (acc_cnt - base) < 2, ((acc_cnt - base) == 0) ? 8'h0F : 8'hF0, 1'b1);
    check("b2b:nbits", 32'(bv_cnt), 32'd16);
    check("b2b:w0_l", 32'(word_l(0, 1)), 32'h0F);
    check("b2b:w1_l", 32'(word_l(8, 1)), 32'hF0);
    check("b2b:w0_m", 32'(word_m(0, 1)), 32'h0F);
    check("b2b:w1_m", 32'(word_m(8, 1)), 32'hF0);

    // bit_en every third cycle; acceptance happens on a cycle without bit_en.
    clear_rx();
    cycle("div3", 1'b1, 8'h3C, 1'b0);
    for (int i = 0; i < 40; i++) cycle("div3", 1'b0, 8'($urandom), (i % 3) == 0);
    check("div3:nbits", 32'(bv_cnt), 32'd24);
    check("div3:word_l", 32'(word_l(0, 3)), 32'h3C);
    check("div3:word_m", 32'(word_m(0, 3)), 32'h3C);

    // Reset mid-word with a second word held.
    base = acc_cnt;
    for (int i = 0; i < 20; i++) begin
      if (idx == 3 && cur == 8'h81) break;
      cycle("rst", (acc_cnt - base) < 2, ((acc_cnt - base) == 0) ? 8'h81 : 8'h7E, 1'b1);
    end
    check("rst:held", 32'(pend.size()), 32'd1);
    in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    pend.delete();
    idx = -1;
    check_outputs("rst_async");
    @(posedge clk);
    #1 check_outputs("rst_hold");
    @(negedge clk);
    reset_n = 1'b1;
    clear_rx();
    cycle("post", 1'b1, 8'h55, 1'b1);
    repeat (12) cycle("post", 1'b0, 8'h00, 1'b1);
    check("post:nbits", 32'(bv_cnt), 32'd8);
    check("post:word_l", 32'(word_l(0, 1)), 32'h55);
    check("post:word_m", 32'(word_m(0, 1)), 32'h55);

    // Random traffic: in_data changes every cycle, so only handshake-edge data may be sent.
    repeat (400)
      cycle("rand", 1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 3) != 0);
    repeat (30) cycle("drain", 1'b0, 8'h00, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the parallel word width (legal range 2..32).
REQ-002 The block SHALL have parameter MSB_FIRST, default 0: 0 transmits bit 0 first, 1 transmits bit DATA_W-1 first.
REQ-003 The block SHALL have parameter IDLE_LEVEL, default 0, giving the serial_out level when no word is being shifted.
REQ-004 Port clk, input, 1 bit: rising-edge clock for all state.
REQ-005 Port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port in_data, input, DATA_W bits: parallel word to serialize.
REQ-007 Port in_valid, input, 1 bit: in_data is valid.
REQ-008 Port in_ready, output, 1 bit: the holding register can accept a word.
REQ-009 Port bit_en, input, 1 bit: bit-rate tick; the shifter advances only on cycles with bit_en=1.
REQ-010 Port serial_out, output, 1 bit: serial bit stream, suitable to drive a downstream serial_in.
REQ-011 Port bit_valid, output, 1 bit: serial_out carries a data bit.
REQ-012 Port frame_start, output, 1 bit: high while the first bit of a word is driven.
REQ-013 Port frame_last, output, 1 bit: high while the last bit of a word is driven.

Function
REQ-014 The block SHALL contain a one-word holding register (hold_data, hold_full) and a shift register with a bit counter of width clog2(DATA_W).
REQ-015 in_ready SHALL equal !hold_full (combinational); a handshake occurs on a rising edge where in_valid && in_ready, and hold_full sets at that edge.
REQ-016 Acceptance into the holding register SHALL NOT depend on bit_en.
REQ-017 The shifter FSM SHALL have two states: IDLE and SHIFT.
REQ-018 IDLE -> SHIFT: on an edge with bit_en=1 and hold_full=1; the shifter loads hold_data, the counter clears to 0 and hold_full clears.
REQ-019 In SHIFT, on an edge with bit_en=1 and counter<DATA_W-1, the counter SHALL increment and the shifter SHALL advance by one bit toward the output end.
REQ-020 In SHIFT, on an edge with bit_en=1 and counter==DATA_W-1: if hold_full, the next word SHALL load immediately (counter=0, hold_full clears, no idle gap); otherwise the FSM SHALL return to IDLE.
REQ-021 With bit_en=0 in SHIFT, all shifter state SHALL hold and serial_out SHALL stay stable.
REQ-022 In SHIFT, serial_out SHALL be the current output-end bit (LSB if MSB_FIRST=0, else MSB) and bit_valid SHALL be 1; in IDLE, serial_out=IDLE_LEVEL and bit_valid=0.
REQ-023 frame_start SHALL be 1 iff SHIFT && counter==0; frame_last SHALL be 1 iff SHIFT && counter==DATA_W-1; each stays high for as many cycles as that bit is held.
REQ-024 Latency with bit_en tied to 1: a handshake at edge E SHALL drive bit 0 of the word from edge E+1, and the last bit SHALL be held through edge E+DATA_W.
REQ-025 When a new word is accepted on the same edge that the holding register drains into the shifter, it SHALL NOT be accepted (in_ready was 0); no word SHALL ever be dropped or duplicated.
REQ-026 With bit_en=1 continuously and in_valid held high, sustained throughput SHALL be one word per DATA_W cycles, with bit_valid continuously high.
REQ-027 in_data SHALL be sampled only at the handshake edge; changes afterwards SHALL NOT affect the transmitted word.

Reset
REQ-028 While reset_n=0, the block SHALL immediately force: state IDLE, hold_full=0, counter=0, shifter=0.
REQ-029 Output values under reset SHALL be: serial_out=IDLE_LEVEL, bit_valid=0, frame_start=0, frame_last=0, in_ready=1.
REQ-030 Reset asserted mid-word SHALL abandon both the in-flight word and the held word; after release, the next accepted word SHALL transmit normally.

Verification
REQ-031 DATA_W=8, MSB_FIRST=0, bit_en=1, one word 0xA5 -> serial_out 1,0,1,0,0,1,0,1 on edges E+1..E+8, frame_start at E+1, frame_last at E+8, then IDLE_LEVEL.
REQ-032 MSB_FIRST=1, word 0xA5 -> serial_out 1,0,1,0,0,1,0,1 read MSB to LSB; bit_valid high for exactly 8 cycles.
REQ-033 Back-to-back 0x0F then 0xF0, in_valid held high -> 16 consecutive bit_valid cycles with no gap; in_ready low while the held word waits.
REQ-034 bit_en=1 every 3rd cycle, word 0x3C -> each bit held 3 cycles; frame_start and frame_last each high for 3 cycles; 24 cycles total.
REQ-035 Assert reset_n=0 after bit 3 of 0x81 with 0x7E held -> outputs go to reset values without waiting for a clock; after release, word 0x55 transmits 1,0,1,0,1,0,1,0 and neither 0x81 nor 0x7E reappears.
REQ-036 in_valid high while hold_full=1 -> in_ready=0 and no acceptance; in_data changed after handshake -> transmitted word unchanged.
